// File: rtl/vce_pkg.sv
// Shared VCE types: CRAM words, addresses and the CPU access FSM.
// Imported by the colour RAM arbiter and its bench.
package vce_pkg;

  localparam int CRAM_DEPTH = 512;

  typedef logic [8:0] color_t;
  typedef logic [8:0] cram_addr_t;

  typedef enum logic [1:0] {
    C_IDLE,
    C_PEND,
    C_RDATA,
    C_DONE
  } cpu_state_t;

endpackage

// File: rtl/vce_cram_arbiter_if.sv
// CPU MMIO colour-table port: request/busy/ack handshake.
// The master issues requests; the arbiter is the slave.
interface vce_cram_arbiter_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 9
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_busy;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_overrun;

  modport master (
    output cpu_req,
    output cpu_we,
    output cpu_addr,
    output cpu_wdata,
    input  cpu_busy,
    input  cpu_ack,
    input  cpu_rdata,
    input  cpu_overrun
  );

  modport slave (
    input  cpu_req,
    input  cpu_we,
    input  cpu_addr,
    input  cpu_wdata,
    output cpu_busy,
    output cpu_ack,
    output cpu_rdata,
    output cpu_overrun
  );

endinterface

// File: rtl/vce_cram_arbiter.sv
// Single-port CRAM scheduler: pixel palette fetch has priority,
// a bounded-wait CPU access may steal a pixel slot (colour repeats).
module vce_cram_arbiter
  import vce_pkg::*;
#(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 9,
  parameter int MAX_WAIT = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_artifact,
  vce_cram_arbiter_if.slave cpu,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int WCW =
    (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  cpu_state_t        state;
  cpu_state_t        state_nxt;
  logic [WCW-1:0]    wait_cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic              grant_cpu;
  logic              p1_valid;
  logic              p1_stolen;

  // CPU wins an idle slot, or any slot once it has waited long enough
  assign grant_cpu = (state == C_PEND) &&
                     (!pix_req || wait_cnt == WMAX);

  always_ff @(posedge clock) begin
    if (reset) state <= C_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      C_IDLE:  if (cpu.cpu_req) state_nxt = C_PEND;
      C_PEND:  if (grant_cpu)
                 state_nxt = lat_we ? C_DONE : C_RDATA;
      C_RDATA: state_nxt = C_DONE;
      C_DONE:  state_nxt = C_IDLE;
      default: state_nxt = C_IDLE;
    endcase
  end

  always_comb begin
    cpu.cpu_busy = (state != C_IDLE);
    cpu.cpu_ack  = (state == C_DONE);
    ram_addr     = grant_cpu ? lat_addr : pix_addr;
    ram_we       = grant_cpu && lat_we;
    ram_wdata    = lat_wdata;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wait_cnt        <= '0;
      lat_we          <= 1'b0;
      lat_addr        <= '0;
      lat_wdata       <= '0;
      cpu.cpu_rdata   <= '0;
      cpu.cpu_overrun <= 1'b0;
    end else begin
      if (state == C_IDLE && cpu.cpu_req) begin
        lat_we    <= cpu.cpu_we;
        lat_addr  <= cpu.cpu_addr;
        lat_wdata <= cpu.cpu_wdata;
        wait_cnt  <= '0;
      end
      if (state == C_PEND && !grant_cpu && wait_cnt != WMAX)
        wait_cnt <= wait_cnt + WCW'(1);
      if (state == C_RDATA)
        cpu.cpu_rdata <= ram_rdata;
      if (state != C_IDLE && cpu.cpu_req)
        cpu.cpu_overrun <= 1'b1;
    end
  end

  // Two-stage pixel pipe; a stolen slot holds the last colour
  always_ff @(posedge clock) begin
    if (reset) begin
      p1_valid     <= 1'b0;
      p1_stolen    <= 1'b0;
      pix_valid    <= 1'b0;
      pix_artifact <= 1'b0;
      pix_data     <= '0;
    end else begin
      p1_valid     <= pix_req;
      p1_stolen    <= pix_req && grant_cpu;
      pix_valid    <= p1_valid;
      pix_artifact <= p1_stolen;
      if (p1_valid && !p1_stolen)
        pix_data <= ram_rdata;
    end
  end

endmodule

// File: tb/tb_vce_cram_arbiter.sv
// Directed bench for vce_cram_arbiter with a behavioural 512x9 CRAM.
// Backdoor preload runs while the DUT is held in reset.
module tb_vce_cram_arbiter;
  import vce_pkg::*;

  logic       clock;
  logic       reset;
  logic       pix_req;
  logic [8:0] pix_addr;
  logic       pix_valid;
  logic [8:0] pix_data;
  logic       pix_artifact;
  logic [8:0] ram_addr;
  logic       ram_we;
  logic [8:0] ram_wdata;
  logic [8:0] ram_rdata;

  logic       bd_we;
  logic [8:0] bd_addr;
  logic [8:0] bd_data;
  color_t     mem [CRAM_DEPTH];

  int n_chk = 0;
  int n_err = 0;

  vce_cram_arbiter_if cpu_if ();

  vce_cram_arbiter dut (
    .clock        (clock),
    .reset        (reset),
    .pix_req      (pix_req),
    .pix_addr     (pix_addr),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_artifact (pix_artifact),
    .cpu          (cpu_if),
    .ram_addr     (ram_addr),
    .ram_we       (ram_we),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (bd_we)       mem[bd_addr] <= bd_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  function automatic logic [8:0] f(input int a);
    if (a == 16) return 9'h0AA;
    return 9'(a * 37 + 11);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_pv"},   32'(pix_valid), 0);
    chk({tag, "_pd"},   32'(pix_data), 0);
    chk({tag, "_pa"},   32'(pix_artifact), 0);
    chk({tag, "_busy"}, 32'(cpu_if.cpu_busy), 0);
    chk({tag, "_ack"},  32'(cpu_if.cpu_ack), 0);
    chk({tag, "_rd"},   32'(cpu_if.cpu_rdata), 0);
    chk({tag, "_ovr"},  32'(cpu_if.cpu_overrun), 0);
    chk({tag, "_we"},   32'(ram_we), 0);
    chk({tag, "_ra"},   32'(ram_addr), 0);
    chk({tag, "_rw"},   32'(ram_wdata), 0);
  endtask

  task automatic cpu_drive(input logic req, input logic we,
                           input logic [8:0] a, input logic [8:0] d);
    cpu_if.cpu_req   = req;
    cpu_if.cpu_we    = we;
    cpu_if.cpu_addr  = a;
    cpu_if.cpu_wdata = d;
  endtask

  initial begin
    int acks;
    int wes;
    reset   = 1'b1;
    pix_req = 1'b0;
    pix_addr = '0;
    bd_we   = 1'b0;
    bd_addr = '0;
    bd_data = '0;
    cpu_drive(1'b0, 1'b0, 9'h0, 9'h0);
    cyc();

    for (int a = 0; a < 64; a++) begin
      bd_we   = 1'b1;
      bd_addr = 9'(a);
      bd_data = f(a);
      cyc();
    end
    bd_we = 1'b0;

    // reset with both requesters active
    pix_req = 1'b1;
    cpu_drive(1'b1, 1'b1, 9'h003, 9'h007);
    for (int t = 0; t < 2; t++) begin
      @(negedge clock);
      zero_check("rst");
      cyc();
    end
    reset   = 1'b0;
    pix_req = 1'b0;
    cpu_drive(1'b0, 1'b0, 9'h0, 9'h0);
    @(negedge clock);
    zero_check("post_rst");
    cyc();

    // uncontended write, then read back through the pixel path
    for (int t = 0; t < 4; t++) begin
      cpu_drive(t == 0, 1'b1, 9'h005, 9'h1FF);
      @(negedge clock);
      chk("t2_ack", 32'(cpu_if.cpu_ack), 32'(t == 2));
      if (t == 1) begin
        chk("t2_we",   32'(ram_we), 1);
        chk("t2_addr", 32'(ram_addr), 32'h005);
        chk("t2_wd",   32'(ram_wdata), 32'h1FF);
        chk("t2_busy", 32'(cpu_if.cpu_busy), 1);
      end
      cyc();
    end
    for (int t = 0; t < 3; t++) begin
      pix_req  = (t == 0);
      pix_addr = 9'h005;
      @(negedge clock);
      chk("t2_pv", 32'(pix_valid), 32'(t == 2));
      if (t == 2) begin
        chk("t2_pd", 32'(pix_data), 32'h1FF);
        chk("t2_pa", 32'(pix_artifact), 0);
      end
      cyc();
    end

    // read under a continuous pixel stream: slot R+4 is stolen
    for (int t = 0; t < 9; t++) begin
      cpu_drive(t == 0, 1'b0, 9'h010, 9'h000);
      pix_req  = (t <= 6);
      pix_addr = 9'(9'h011 + t);
      @(negedge clock);
      chk("t3_ack", 32'(cpu_if.cpu_ack), 32'(t == 6));
      chk("t3_pv",  32'(pix_valid), 32'(t >= 2));
      if (t >= 2) begin
        chk("t3_pa", 32'(pix_artifact), 32'(t == 6));
        chk("t3_pd", 32'(pix_data),
            32'((t == 6) ? f(9'h014) : f(9'h011 + t - 2)));
      end
      if (t == 4) begin
        chk("t3_ra", 32'(ram_addr), 32'h010);
        chk("t3_we", 32'(ram_we), 0);
      end
      if (t == 6) chk("t3_rd", 32'(cpu_if.cpu_rdata), 32'h0AA);
      cyc();
    end
    pix_req = 1'b0;

    // back-to-back request while busy is dropped and flagged
    acks = 0;
    wes  = 0;
    for (int t = 0; t < 10; t++) begin
      cpu_drive(t <= 1, 1'b1,
                (t == 0) ? 9'h020 : 9'h021,
                (t == 0) ? 9'h123 : 9'h000);
      pix_req  = (t == 5 || t == 7);
      pix_addr = (t == 5) ? 9'h020 : 9'h021;
      @(negedge clock);
      acks += int'(cpu_if.cpu_ack);
      wes  += int'(ram_we);
      chk("t4_ovr", 32'(cpu_if.cpu_overrun), 32'(t >= 2));
      if (t == 1) begin
        chk("t4_ra", 32'(ram_addr), 32'h020);
        chk("t4_wd", 32'(ram_wdata), 32'h123);
      end
      if (t == 7) chk("t4_pd20", 32'(pix_data), 32'h123);
      if (t == 9) chk("t4_pd21", 32'(pix_data), 32'(f(9'h021)));
      cyc();
    end
    chk("t4_acks", 32'(acks), 1);
    chk("t4_wes",  32'(wes), 1);

    // reset while the read is in C_RDATA
    for (int t = 0; t < 5; t++) begin
      cpu_drive(t == 0, 1'b0, 9'h010, 9'h000);
      pix_req = 1'b0;
      reset   = (t == 2);
      @(negedge clock);
      chk("t5_ack", 32'(cpu_if.cpu_ack), 0);
      if (t == 2) chk("t5_busy_in", 32'(cpu_if.cpu_busy), 1);
      if (t == 3) begin
        chk("t5_busy", 32'(cpu_if.cpu_busy), 0);
        chk("t5_rd",   32'(cpu_if.cpu_rdata), 0);
        chk("t5_ovr",  32'(cpu_if.cpu_overrun), 0);
      end
      cyc();
    end
    reset = 1'b0;

    // alternating pixel slots: write lands in the first gap
    for (int t = 0; t < 9; t++) begin
      cpu_drive(t == 0, 1'b1, 9'h030, 9'h155);
      pix_req  = (t == 1 || t == 3 || t == 5);
      pix_addr = (t == 3) ? 9'h013 : 9'h030;
      @(negedge clock);
      chk("t6_we",  32'(ram_we), 32'(t == 2));
      chk("t6_ack", 32'(cpu_if.cpu_ack), 32'(t == 3));
      chk("t6_pv",  32'(pix_valid), 32'(t == 3 || t == 5 || t == 7));
      chk("t6_pa",  32'(pix_artifact), 0);
      if (t == 2) chk("t6_ra", 32'(ram_addr), 32'h030);
      if (t == 3) chk("t6_pd3", 32'(pix_data), 32'(f(9'h030)));
      if (t == 5) chk("t6_pd5", 32'(pix_data), 32'(f(9'h013)));
      if (t == 7) chk("t6_pd7", 32'(pix_data), 32'h155);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
